// File: rtl/inventory_pkg.sv
// Shared types and constants for the per-stock inventory tracker.
package inventory_pkg;

  localparam int NUM_STOCKS_DEF = 8;
  localparam int POS_WIDTH_DEF  = 32;

  typedef logic [$clog2(NUM_STOCKS_DEF)-1:0] stock_id_t;
  typedef logic signed [POS_WIDTH_DEF-1:0]   position_t;

  // Fill side: a bid fill buys (position grows), an ask fill sells.
  localparam logic SIDE_BID = 1'b0;
  localparam logic SIDE_ASK = 1'b1;

endpackage

// File: rtl/inventory_norm_mult.sv
// Stage 2 of the read path: signed position x unsigned reciprocal,
// registered, with the result clamped to the signed output range.
module inventory_norm_mult
  import inventory_pkg::*;
#(
  parameter int POS_WIDTH    = 32,
  parameter int FP_WORD_SIZE = 64
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_en,
  input  logic signed [POS_WIDTH-1:0]    i_pos,
  input  logic [FP_WORD_SIZE-1:0]        i_recip,
  output logic signed [FP_WORD_SIZE-1:0] o_norm
);

  // One extra bit keeps the unsigned reciprocal positive inside a signed product.
  localparam int P_W = POS_WIDTH + FP_WORD_SIZE + 1;

  logic signed [P_W-1:0]          a_ext;
  logic signed [P_W-1:0]          b_ext;
  logic signed [P_W-1:0]          prod;
  logic [P_W-FP_WORD_SIZE:0]      upper;
  logic                           ovf;
  logic signed [FP_WORD_SIZE-1:0] norm_d;
  logic signed [FP_WORD_SIZE-1:0] norm_q;

  assign a_ext = {{(P_W-POS_WIDTH){i_pos[POS_WIDTH-1]}}, i_pos};
  assign b_ext = {{(P_W-FP_WORD_SIZE){1'b0}}, i_recip};
  assign prod  = a_ext * b_ext;

  // The result fits only if every bit above the output sign bit matches it.
  assign upper = prod[P_W-1:FP_WORD_SIZE-1];
  assign ovf   = !((&upper) || (~|upper));

  // Select the in-range product or the saturation bound matching its sign.
  always_comb begin
    norm_d = prod[FP_WORD_SIZE-1:0];
    if (ovf) begin
      norm_d = prod[P_W-1] ? {1'b1, {(FP_WORD_SIZE-1){1'b0}}}
                           : {1'b0, {(FP_WORD_SIZE-1){1'b1}}};
    end
  end

  // Output register updates only for a valid read so the value holds between reads.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      norm_q <= '0;
    end else if (i_en) begin
      norm_q <= norm_d;
    end
  end

  assign o_norm = norm_q;

endmodule

// File: rtl/inventory_tracker.sv
// Per-stock signed position tracker with saturating updates and a
// 2-stage normalised read path (select/limit, then multiply).
module inventory_tracker
  import inventory_pkg::*;
#(
  parameter int FP_WORD_SIZE = 64,
  parameter int FRAC_BITS    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int POS_WIDTH    = 32,
  parameter int NUM_STOCKS   = 8,
  parameter int MAX_POSITION = 1000
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_execute_order,
  input  logic [$clog2(NUM_STOCKS)-1:0]   i_execute_stock_id,
  input  logic                            i_execute_order_side,
  input  logic [DATA_WIDTH-1:0]           i_execute_order_quantity,
  input  logic                            i_clear,
  input  logic                            i_ren,
  input  logic [$clog2(NUM_STOCKS)-1:0]   i_stock_id,
  input  logic [FP_WORD_SIZE-1:0]         i_max_inventory_reciprocal,
  output logic                            o_valid,
  output logic signed [FP_WORD_SIZE-1:0]  o_norm_inventory,
  output logic signed [POS_WIDTH-1:0]     o_position,
  output logic                            o_limit_hit
);

  localparam int ID_W  = $clog2(NUM_STOCKS);
  // Wide enough that pos +/- any quantity never wraps before clamping.
  localparam int SUM_W = ((POS_WIDTH > DATA_WIDTH) ? POS_WIDTH : DATA_WIDTH) + 2;
  localparam logic signed [SUM_W-1:0]     MAX_S = SUM_W'(MAX_POSITION);
  localparam logic signed [POS_WIDTH-1:0] MAX_P = POS_WIDTH'(MAX_POSITION);

  if (FRAC_BITS >= FP_WORD_SIZE) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than FP_WORD_SIZE");
  end

  logic signed [POS_WIDTH-1:0] pos_q [NUM_STOCKS];
  logic signed [POS_WIDTH-1:0] pos_d [NUM_STOCKS];
  logic signed [POS_WIDTH-1:0] exec_cur;
  logic signed [POS_WIDTH-1:0] exec_new;
  logic signed [POS_WIDTH-1:0] rd_pos;
  logic                        rd_limit;
  logic signed [SUM_W-1:0]     qty_ext;
  logic signed [SUM_W-1:0]     sum;

  logic                        s1_valid_q;
  logic signed [POS_WIDTH-1:0] s1_pos_q;
  logic [FP_WORD_SIZE-1:0]     s1_recip_q;
  logic                        s1_limit_q;

  logic                        valid_q;
  logic signed [POS_WIDTH-1:0] position_q;
  logic                        limit_q;

  assign qty_ext = {{(SUM_W-DATA_WIDTH){1'b0}}, i_execute_order_quantity};

  // Fetch the current position of the stock being executed (0 if out of range).
  always_comb begin
    exec_cur = '0;
    for (int i = 0; i < NUM_STOCKS; i++) begin
      if (i_execute_stock_id == ID_W'(i)) exec_cur = pos_q[i];
    end
  end

  // Apply the fill at full width, then clamp to +/-MAX_POSITION.
  always_comb begin
    sum = {{(SUM_W-POS_WIDTH){exec_cur[POS_WIDTH-1]}}, exec_cur};
    if (i_execute_order_side == SIDE_ASK) sum = sum - qty_ext;
    else                                  sum = sum + qty_ext;
    if (sum > MAX_S)       exec_new = MAX_P;
    else if (sum < -MAX_S) exec_new = -MAX_P;
    else                   exec_new = sum[POS_WIDTH-1:0];
  end

  // Next position per stock; a clear wins over a fill on the same stock.
  always_comb begin
    for (int i = 0; i < NUM_STOCKS; i++) begin
      pos_d[i] = pos_q[i];
      if (i_execute_stock_id == ID_W'(i)) begin
        if (i_clear)              pos_d[i] = '0;
        else if (i_execute_order) pos_d[i] = exec_new;
      end
    end
  end

  // Position registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_STOCKS; i++) pos_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STOCKS; i++) pos_q[i] <= pos_d[i];
    end
  end

  // Read select uses next-state values so a same-cycle update is bypassed.
  always_comb begin
    rd_pos = '0;
    for (int i = 0; i < NUM_STOCKS; i++) begin
      if (i_stock_id == ID_W'(i)) rd_pos = pos_d[i];
    end
    rd_limit = (rd_pos >= MAX_P) || (rd_pos <= -MAX_P);
  end

  // Stage 1: capture position, reciprocal and limit flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s1_pos_q   <= '0;
      s1_recip_q <= '0;
      s1_limit_q <= 1'b0;
    end else begin
      s1_valid_q <= i_ren;
      if (i_ren) begin
        s1_pos_q   <= rd_pos;
        s1_recip_q <= i_max_inventory_reciprocal;
        s1_limit_q <= rd_limit;
      end
    end
  end

  // Stage 2: publish valid strobe and side-band outputs alongside the product.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      position_q <= '0;
      limit_q    <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        position_q <= s1_pos_q;
        limit_q    <= s1_limit_q;
      end
    end
  end

  inventory_norm_mult #(
    .POS_WIDTH    (POS_WIDTH),
    .FP_WORD_SIZE (FP_WORD_SIZE)
  ) u_norm_mult (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (s1_valid_q),
    .i_pos   (s1_pos_q),
    .i_recip (s1_recip_q),
    .o_norm  (o_norm_inventory)
  );

  assign o_valid     = valid_q;
  assign o_position  = position_q;
  assign o_limit_hit = limit_q;

endmodule

// File: tb/tb_inventory_tracker.sv
// Randomised bench for inventory_tracker against a behavioural position model.
module tb_inventory_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exec_o = 1'b0;
  logic [2:0]  exec_id = '0;
  logic        side = 1'b0;
  logic [31:0] qty = '0;
  logic        clr = 1'b0;
  logic        ren = 1'b0;
  logic [2:0]  rd_id = '0;
  logic [63:0] recip = 64'h418937;

  logic               o_valid;
  logic signed [63:0] o_norm;
  logic signed [31:0] o_pos;
  logic               o_lim;

  int checks   = 0;
  int failures = 0;
  int valid_seen = 0;

  // Reference model state
  int          mpos [8];
  bit          s1_v = 0;
  int          s1_pos = 0;
  logic [63:0] s1_norm = '0;
  bit          s1_lim = 0;
  int          last_pos = 0;
  logic [63:0] last_norm = '0;
  bit          last_lim = 0;

  always #5 clk = ~clk;

  inventory_tracker dut (
    .i_clk                      (clk),
    .i_reset                    (rst),
    .i_execute_order            (exec_o),
    .i_execute_stock_id         (exec_id),
    .i_execute_order_side       (side),
    .i_execute_order_quantity   (qty),
    .i_clear                    (clr),
    .i_ren                      (ren),
    .i_stock_id                 (rd_id),
    .i_max_inventory_reciprocal (recip),
    .o_valid                    (o_valid),
    .o_norm_inventory           (o_norm),
    .o_position                 (o_pos),
    .o_limit_hit                (o_lim)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] norm_of(input int p, input logic [63:0] r);
    logic signed [127:0] a, b, prod, hi, lo;
    a = p;
    b = {64'd0, r};
    prod = a * b;
    hi = 128'sh7fff_ffff_ffff_ffff;
    lo = -hi - 128'sd1;
    if (prod > hi) return 64'h7fff_ffff_ffff_ffff;
    if (prod < lo) return 64'h8000_0000_0000_0000;
    return prod[63:0];
  endfunction

  // Apply this cycle's inputs to the model, clock once, compare outputs.
  task automatic cycle();
    bit          nv;
    int          npos;
    logic [63:0] nnorm;
    bit          nlim;
    longint      s;
    if (clr) begin
      mpos[exec_id] = 0;
    end else if (exec_o) begin
      s = longint'(mpos[exec_id]);
      if (side) s = s - longint'({32'd0, qty});
      else      s = s + longint'({32'd0, qty});
      if (s > 1000)  s = 1000;
      if (s < -1000) s = -1000;
      mpos[exec_id] = int'(s);
    end
    nv = ren;
    npos = 0; nnorm = '0; nlim = 0;
    if (ren) begin
      npos  = mpos[rd_id];
      nnorm = norm_of(npos, recip);
      nlim  = (npos >= 1000) || (npos <= -1000);
    end
    @(posedge clk);
    #1;
    check("valid", {63'd0, o_valid}, {63'd0, s1_v});
    if (s1_v) begin
      last_pos = s1_pos; last_norm = s1_norm; last_lim = s1_lim;
    end
    s1_v = nv;
    if (nv) begin
      s1_pos = npos; s1_norm = nnorm; s1_lim = nlim;
    end
    check("position", 64'(o_pos), 64'(last_pos));
    check("norm", o_norm, last_norm);
    check("limit", {63'd0, o_lim}, {63'd0, last_lim});
    if (o_valid === 1'b1) valid_seen++;
  endtask

  task automatic idle();
    exec_o = 0; clr = 0; ren = 0; qty = '0;
  endtask

  // Asynchronous reset pulse between two clock edges.
  task automatic reset_pulse();
    idle();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_pos", 64'(o_pos), 64'd0);
    check("rst_norm", o_norm, 64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) mpos[i] = 0;
    s1_v = 0; last_pos = 0; last_norm = '0; last_lim = 0;
  endtask

  task automatic read(input int id);
    ren = 1; rd_id = 3'(id);
    cycle();
    ren = 0;
    cycle();
  endtask

  task automatic fill(input int id, input bit sd, input logic [31:0] q);
    exec_o = 1; exec_id = 3'(id); side = sd; qty = q;
    cycle();
    exec_o = 0;
  endtask

  initial begin
    logic [63:0] e;
    int vs;
    for (int i = 0; i < 8; i++) mpos[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("init_valid", {63'd0, o_valid}, 64'd0);
    check("init_norm", o_norm, 64'd0);
    rst = 1'b0;

    // Read after reset
    recip = 64'h418937;
    read(3);
    check("rd3_valid", {63'd0, o_valid}, 64'd1);
    check("rd3_pos", 64'(o_pos), 64'd0);

    // Bid 500 on stock 1
    fill(1, 0, 32'd500);
    read(1);
    check("bid500_pos", 64'(o_pos), 64'd500);
    check("bid500_norm", o_norm, 64'd2147483500);
    check("bid500_lim", {63'd0, o_lim}, 64'd0);

    // Ask 700 then 600 on stock 2 clamps to -1000
    fill(2, 1, 32'd700);
    fill(2, 1, 32'd600);
    read(2);
    e = -64'sd4294967000;
    check("ask_pos", 64'(o_pos), -64'sd1000);
    check("ask_norm", o_norm, e);
    check("ask_lim", {63'd0, o_lim}, 64'd1);

    // Same-cycle bypass and clear priority on stock 0
    fill(0, 0, 32'd5);
    exec_o = 1; exec_id = 0; side = 0; qty = 32'd10; ren = 1; rd_id = 0;
    cycle();
    idle();
    cycle();
    check("bypass_pos", 64'(o_pos), 64'd15);
    clr = 1; exec_o = 1; exec_id = 0; qty = 32'd10; ren = 1; rd_id = 0;
    cycle();
    idle();
    cycle();
    check("clear_pos", 64'(o_pos), 64'd0);

    // Four back-to-back reads
    vs = valid_seen;
    for (int i = 0; i < 4; i++) begin
      ren = 1; rd_id = 3'(i);
      cycle();
    end
    idle();
    repeat (3) cycle();
    check("b2b_count", 64'(valid_seen - vs), 64'd4);

    // Reset between edges 1 and 2 of a read
    ren = 1; rd_id = 1;
    cycle();
    reset_pulse();
    vs = valid_seen;
    repeat (3) cycle();
    check("rst_drop", 64'(valid_seen - vs), 64'd0);
    for (int i = 0; i < 8; i++) read(i);

    // Saturated product and huge quantity clamps
    recip = 64'hffff_ffff_ffff_ffff;
    fill(4, 0, 32'd1500);
    read(4);
    check("sat_norm", o_norm, 64'h7fff_ffff_ffff_ffff);
    fill(5, 1, 32'hffff_ffff);
    read(5);
    check("huge_pos", 64'(o_pos), -64'sd1000);
    fill(5, 0, 32'd0);
    read(5);
    check("zero_qty", 64'(o_pos), -64'sd1000);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      exec_o  = ($urandom_range(0, 2) != 0);
      exec_id = 3'($urandom_range(0, 7));
      side    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: qty = 32'($urandom_range(0, 20));
        1: qty = 32'($urandom_range(0, 1500));
        2: qty = 32'd0;
        default: qty = $urandom;
      endcase
      clr   = ($urandom_range(0, 15) == 0);
      ren   = 1'($urandom_range(0, 1));
      rd_id = ($urandom_range(0, 3) == 0) ? exec_id : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: recip = 64'h418937;
        1: recip = 64'hffff_ffff_ffff_ffff;
        2: recip = {$urandom, $urandom};
        default: recip = 64'h1_0000_0000;
      endcase
      if ($urandom_range(0, 199) == 0) reset_pulse();
      cycle();
    end
    idle();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
